// File: rtl/lcd_write_sequencer.sv
// LCD write sequencer: request FIFO plus setup/strobe/hold/gap write FSM.
// Optional power-on init ROM enabled by defining LCD_INIT_EN.
module lcd_write_sequencer #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int STROBE_CYC   = 2,
    parameter int GAP_CYC      = 4,
    parameter int LONG_GAP_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             reqData,
    input  logic                          reqIsCmd,
    input  logic                          reqLong,
    input  logic                          reqValid,
    output logic                          reqReady,
    output logic [DATA_W-1:0]             commData,
    output logic [ADDR_W-1:0]             commAddr,
    output logic                          wrEn,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          initDone
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int EW    = DATA_W + 2;
    localparam int CNT_W = $clog2(LONG_GAP_CYC + STROBE_CYC + 1);

    localparam logic [ADDR_W-1:0] ADDR_CMD = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_DAT = ADDR_W'(2);
    localparam logic [CNT_W-1:0]  STB_LD   = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  LGAP_LD  = CNT_W'(LONG_GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              long_q, long_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic [PW-1:0]     level_q, level_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [EW-1:0]     head;
    logic              full, empty, push, init_done;

`ifdef LCD_INIT_EN
    logic              init_done_q, init_done_d;
    logic [2:0]        init_idx_q, init_idx_d;
    logic [DATA_W-1:0] init_byte;

    // Init ROM: function set, display on, entry mode, clear
    always_comb begin
        init_byte = DATA_W'(8'h01);
        unique case (init_idx_q[1:0])
            2'd0:    init_byte = DATA_W'(8'h38);
            2'd1:    init_byte = DATA_W'(8'h0C);
            2'd2:    init_byte = DATA_W'(8'h06);
            default: init_byte = DATA_W'(8'h01);
        endcase
    end

    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign reqReady  = !full && init_done;
    assign push      = reqValid && reqReady;
    assign commData  = data_q;
    assign commAddr  = addr_q;
    assign wrEn      = wr_en_q;
    assign busy      = busy_q;
    assign fifoLevel = level_q;
    assign initDone  = init_done;

    // FIFO storage; pointers alone define occupancy, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {reqLong, reqIsCmd, reqData};
        end
    end

    // Next-state, pop and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        addr_d   = addr_q;
        long_d   = long_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
`ifdef LCD_INIT_EN
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q ||
                      (state_q == S_GAP && cnt_q == '0 && init_idx_q == 3'd4);
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef LCD_INIT_EN
                if (!init_done_q) begin
                    data_d     = init_byte;
                    addr_d     = ADDR_CMD;
                    long_d     = (init_idx_q == 3'd3);
                    init_idx_d = init_idx_q + 3'd1;
                    state_d    = S_SETUP;
                end else
`endif
                if (!empty) begin
                    data_d   = head[DATA_W-1:0];
                    addr_d   = head[DATA_W] ? ADDR_CMD : ADDR_DAT;
                    long_d   = head[DATA_W+1];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = STB_LD;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_HOLD: begin
                cnt_d   = long_q ? LGAP_LD : GAP_LD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        wr_en_d = (state_d == S_STROBE);
        level_d = wr_ptr_d - rd_ptr_d;
        busy_d  = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
`ifdef LCD_INIT_EN
        busy_d  = busy_d || !init_done_d;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            long_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            level_q  <= '0;
`ifdef LCD_INIT_EN
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            long_q   <= long_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            level_q  <= level_d;
`ifdef LCD_INIT_EN
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
`endif
        end
    end
endmodule
